// File: rtl/mem_bank_arb_pkg.sv
// Shared types and constants for the four-port memory bank read arbiter.
// Round-robin arbitration is enabled by defining MEM_BANK_ARB_RR_EN; otherwise fixed priority.
package mem_bank_arb_pkg;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int IDX_W  = 2;

    // Address layout: upper bits pick the bank, lower bits the entry within it.
    localparam int BANK_LSB  = 2;
    localparam int BANK_W    = 2;
    localparam int ENTRY_LSB = 0;
    localparam int ENTRY_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Rotation pointer after granting idx; the 2-bit add wraps 3 -> 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/mem_bank_arb_if.sv
// Requester and memory-side signal bundle for mem_bank_arb.
// slave: the arbiter's view; master: clients plus memory model driving it.
interface mem_bank_arb_if;
    import mem_bank_arb_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr_bus;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   mem_ce;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data;

    modport slave (
        input  req, addr_bus, mem_data,
        output ack, rdata, busy, mem_ce, mem_addr
    );

    modport master (
        output req, addr_bus, mem_data,
        input  ack, rdata, busy, mem_ce, mem_addr
    );

endinterface

// File: rtl/mem_bank_arb_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr_i wins.
// With a pointer tied to zero it degenerates into fixed priority, req[0] highest.
module mem_bank_arb_pick
    import mem_bank_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             valid_o
);

    logic [NREQ-1:0]  rot_req;
    logic [IDX_W-1:0] offset;

    // rot_req[k] is the requester k places after the pointer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_req[gi] = req_i[ptr_i + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        valid_o = |req_i;
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                offset = IDX_W'(i);
            end
        end
        gnt_idx_o = ptr_i + offset;
        gnt_o     = valid_o ? (NREQ'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/mem_bank_arb.sv
// Four-port read arbiter in front of the 4-bank memory: grant, one ACCESS cycle, one RESP/ack cycle.
// Define MEM_BANK_ARB_RR_EN for round-robin; undefined gives fixed priority without a pointer register.
module mem_bank_arb
    import mem_bank_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_bank_arb_if.slave bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]  pick_ptr;
    logic [NREQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

`ifdef MEM_BANK_ARB_RR_EN
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    assign pick_ptr = ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid) begin
            ptr_d = next_ptr(pick_idx);
        end
    end
`else
    assign pick_ptr = '0;
`endif

    mem_bank_arb_pick u_pick (
        .req_i     (bus.req),
        .ptr_i     (pick_ptr),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // The address is latched at grant so later changes on the bus are invisible.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    addr_d  = bus.addr_bus[ADDR_W*pick_idx +: ADDR_W];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = bus.mem_data;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_ce   = (state_q == ACCESS);
        bus.mem_addr = (state_q == ACCESS) ? addr_q : '0;
        bus.ack      = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
        bus.rdata    = (state_q == RESP) ? rdata_q : '0;
        bus.busy     = (state_q == ACCESS) || (state_q == RESP);
    end

endmodule

// File: tb/tb_mem_bank_arb.sv
// Self-checking bench for mem_bank_arb: vector table, directed corner sequences, random traffic vs. a timing-level model.
// Expectations follow MEM_BANK_ARB_RR_EN the same way the design does.
module tb_mem_bank_arb;
    import mem_bank_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_bank_arb_if bus();
    logic [DATA_W-1:0] mem [16];

    assign bus.mem_data = bus.mem_ce ? mem[bus.mem_addr] : '0;

    mem_bank_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef MEM_BANK_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] addrs;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_rdata;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [3:0] a);
        bus.addr_bus[ADDR_W*i +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random-phase model state: transaction timing derived from the 3-cycle read rule.
    int         ptr;
    int         since;
    int         g_idx;
    logic [3:0] g_addr;

    function automatic int model_pick(input logic [3:0] r, input int p);
        int best, bestd;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && ((i - p + NREQ) % NREQ) < bestd) begin
                bestd = (i - p + NREQ) % NREQ;
                best  = i;
            end
        end
        return best;
    endfunction

    initial begin
        int exp_i;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.addr_bus = '0;
        for (int a = 0; a < 16; a++) mem[a] = 4'(a);
        #1;
        chk("rst_ack",   32'(bus.ack),      32'h0);
        chk("rst_ce",    32'(bus.mem_ce),   32'h0);
        chk("rst_addr",  32'(bus.mem_addr), 32'h0);
        chk("rst_rdata", 32'(bus.rdata),    32'h0);
        chk("rst_busy",  32'(bus.busy),     32'h0);

        // Each vector starts from reset, so the pointer is 0 and both modes pick the lowest index.
        tbl[0] = '{4'b0100, 16'h0900, 4'b0100, 4'h9};
        tbl[1] = '{4'b0001, 16'h000A, 4'b0001, 4'hA};
        tbl[2] = '{4'b1010, 16'hE030, 4'b0010, 4'h3};
        tbl[3] = '{4'b1111, 16'hFA50, 4'b0001, 4'h0};
        tbl[4] = '{4'b1000, 16'h7000, 4'b1000, 4'h7};
        tbl[5] = '{4'b1100, 16'h5C00, 4'b0100, 4'hC};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.req      = tbl[v].req;
            bus.addr_bus = tbl[v].addrs;
            @(negedge clk);
            chk("vec_ce",   32'(bus.mem_ce),   32'h1);
            chk("vec_addr", 32'(bus.mem_addr), 32'(tbl[v].exp_rdata));
            chk("vec_ack0", 32'(bus.ack),      32'h0);
            chk("vec_busy", 32'(bus.busy),     32'h1);
            @(negedge clk);
            chk("vec_ack",   32'(bus.ack),    32'(tbl[v].exp_ack));
            chk("vec_rdata", 32'(bus.rdata),  32'(tbl[v].exp_rdata));
            chk("vec_ce_lo", 32'(bus.mem_ce), 32'h0);
            bus.req = '0;
            @(negedge clk);
            chk("vec_idle", 32'(bus.busy), 32'h0);
            $display("[TB] vector %0d req=%b ack=%b", v, tbl[v].req, tbl[v].exp_ack);
        end

        // Reset asserted mid-ACCESS clears outputs at once and drops the transaction.
        do_reset();
        set_addr(1, 4'h6);
        bus.req = 4'b0010;
        @(negedge clk);
        chk("mid_ce", 32'(bus.mem_ce), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack",   32'(bus.ack),      32'h0);
        chk("mid_rst_ce",    32'(bus.mem_ce),   32'h0);
        chk("mid_rst_rdata", 32'(bus.rdata),    32'h0);
        chk("mid_rst_busy",  32'(bus.busy),     32'h0);
        chk("mid_rst_addr",  32'(bus.mem_addr), 32'h0);
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_ack",  32'(bus.ack),  32'h0);
            chk("mid_no_busy", 32'(bus.busy), 32'h0);
        end
        $display("[TB] reset mid-access done");

        // All four requesters, each dropping req on its ack.
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 4'(5 * i));
        bus.req = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            repeat (t == 0 ? 2 : 3) @(negedge clk);
            chk("all4_ack",   32'(bus.ack),   32'(1) << t);
            chk("all4_rdata", 32'(bus.rdata), 32'(5 * t));
            bus.req[t] = 1'b0;
            $display("[TB] all4 ack=%b rdata=%0d", bus.ack, bus.rdata);
        end
        @(negedge clk);

        // Fairness: requesters 0 and 3 held continuously.
        do_reset();
        set_addr(0, 4'h2);
        set_addr(3, 4'hD);
        bus.req = 4'b1001;
        for (int t = 0; t < 6; t++) begin
            repeat (t == 0 ? 2 : 3) @(negedge clk);
            exp_i = (RR && (t % 2 == 1)) ? 3 : 0;
            chk("fair_ack",   32'(bus.ack),   32'(1) << exp_i);
            chk("fair_rdata", 32'(bus.rdata), (exp_i == 3) ? 32'hD : 32'h2);
            $display("[TB] fair grant %0d ack=%b", t, bus.ack);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Withdraw before grant: req[1] raised while serving req[0], dropped before IDLE.
        do_reset();
        set_addr(0, 4'h1);
        set_addr(1, 4'h4);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req[1] = 1'b1;
        @(negedge clk);
        chk("wd_ack0", 32'(bus.ack), 32'h1);
        bus.req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("wd_no_ack", 32'(bus.ack), 32'h0);
        end
        // Drop after grant plus address change during ACCESS: ack still comes with the latched address.
        set_addr(1, 4'hB);
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = '0;
        set_addr(1, 4'h3);
        @(negedge clk);
        chk("late_ack",   32'(bus.ack),   32'h2);
        chk("late_rdata", 32'(bus.rdata), 32'hB);
        $display("[TB] withdraw/late-drop ack=%b rdata=%0h", bus.ack, bus.rdata);
        repeat (2) @(negedge clk);

        // Random traffic with random memory contents.
        for (int a = 0; a < 16; a++) mem[a] = 4'($urandom);
        do_reset();
        ptr   = 0;
        since = -1;
        g_idx = 0;
        g_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] exp_ack;
            if (since >= 0) since++;
            exp_ack = (since == 2) ? (4'b0001 << g_idx) : 4'b0000;
            chk("rnd_ce",    32'(bus.mem_ce),   32'(since == 1));
            chk("rnd_addr",  32'(bus.mem_addr), (since == 1) ? 32'(g_addr) : 32'h0);
            chk("rnd_ack",   32'(bus.ack),      32'(exp_ack));
            chk("rnd_rdata", 32'(bus.rdata),    (since == 2) ? 32'(mem[g_addr]) : 32'h0);
            chk("rnd_busy",  32'(bus.busy),     32'(since == 1 || since == 2));
            if (since == 2)
                $display("[TB] rnd cyc=%0d ack=%b rdata=%0h", cyc, bus.ack, bus.rdata);

            for (int i = 0; i < NREQ; i++) begin
                if (since == 2 && i == g_idx) begin
                    if ($urandom_range(1, 0) == 1) set_addr(i, 4'($urandom));
                    else bus.req[i] = 1'b0;
                end else if (since == 1 && i == g_idx) begin
                    if ($urandom_range(3, 0) == 0) bus.req[i] = 1'b0;
                    if ($urandom_range(3, 0) == 0) set_addr(i, 4'($urandom));
                end else if (!bus.req[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        set_addr(i, 4'($urandom));
                        bus.req[i] = 1'b1;
                    end
                end else if ($urandom_range(9, 0) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end

            // Arbitration decision for the coming edge, when the arbiter is back in IDLE.
            if (since == -1 || since >= 3) begin
                if (bus.req != 4'b0000) begin
                    g_idx  = model_pick(bus.req, ptr);
                    g_addr = bus.addr_bus[ADDR_W*g_idx +: ADDR_W];
                    if (RR) ptr = (g_idx + 1) % NREQ;
                    since = 0;
                end else begin
                    since = -1;
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_arb.md
# mem_bank_arb

Four-port read arbiter in front of the 4-bank x 4-entry x 4-bit memory bank. Accepts independent read requests from up to four requesters, grants one per transaction, drives the memory's chip-enable and address, registers the returned data and acknowledges the winning requester. Sits between client blocks and the memory bank, so that memory is the only module that sees a single address/enable pair.

## Interface
- NREQ, 4, number of requesters (fixed at 4 for this revision)
- ADDR_W, 4, address width; bits [3:2] select bank, [1:0] select entry
- DATA_W, 4, data width
- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset; asynchronous, active-low
- req  input  NREQ  per-requester read request, level
- addr_bus  input  NREQ*ADDR_W  requester i address at [ADDR_W*i+ADDR_W-1 : ADDR_W*i]
- ack  output  NREQ  one-hot, one-cycle pulse: read complete for requester i
- rdata  output  DATA_W  read data, valid only while any ack bit is high
- busy  output  1  high in ACCESS and RESP
- mem_ce  output  1  memory chip-enable
- mem_addr  output  ADDR_W  memory address
- mem_data  input  DATA_W  memory read data (high-Z when mem_ce low; ignored then)

## Operation
- States: IDLE, ACCESS, RESP (2-bit encoded).
- IDLE: if req != 0, pick winner, latch grant index and its addr_bus slice, go ACCESS; else stay.
- ACCESS: mem_ce=1, mem_addr=latched address; at next edge capture mem_data into rdata register, go RESP.
- RESP: ack[grant]=1, rdata holds captured value; go IDLE unconditionally.
- Arbitration: round-robin (see Configuration). Pointer starts at 0; after granting i, pointer becomes (i+1) mod NREQ. Search starts at pointer, wraps 3->0.
- Requester rule: hold req and its address stable until ack. Address changes before ack are not seen (address latched at grant). req dropped before grant: request withdrawn, no ack. req dropped after grant: transaction completes, ack still issued.
- req still high during/after its ack cycle is treated as a new request at the next IDLE arbitration.
- Outside ACCESS: mem_ce=0, mem_addr=0. Outside RESP: ack=0, rdata=0.
- Reset (any state, any time): state IDLE, pointer 0, grant index 0, latched address 0, rdata 0, ack 0, mem_ce 0, mem_addr 0, busy 0. In-flight transaction is dropped, no ack.

## Timing
- req sampled at edge k in IDLE -> mem_ce high cycle k..k+1 -> ack high cycle k+1..k+2 -> IDLE after edge k+2.
- Request-to-ack latency: 2 cycles after the sampling edge. Throughput: one read per 3 cycles.
- Simultaneous requests: one grant per IDLE pass; losers wait and are granted in rotation order.
- Back-to-back: requester granted at edge k can be granted again no earlier than edge k+3, and only if no other requester is pending (round-robin).

## Configuration
- MEM_BANK_ARB_RR_EN defined: round-robin arbitration as above.
- Not defined: fixed priority, req[0] highest, req[3] lowest; pointer register removed; all other behaviour identical.

## Structure
- Package mem_bank_arb_pkg: state typedef (IDLE/ACCESS/RESP), NREQ, ADDR_W, DATA_W constants, bank/entry field positions.
- One sub-module: mem_bank_arb_pick — combinational rotating-priority picker (req, pointer -> one-hot grant, grant index, valid); with macro off, pointer tied to 0.

## Test plan
- Reset: rst_n low mid-ACCESS -> ack=0, mem_ce=0, rdata=0, busy=0 immediately; after release, state IDLE.
- Single read: req[2]=1, addr 4'b1001 -> mem_ce high one cycle with mem_addr=9, ack=4'b0100 two cycles after sampling edge, rdata=9.
- All four request, addresses 0,5,10,15, RR on -> acks in order 0,1,2,3, each 3 cycles apart, rdata 0,5,10,15.
- RR fairness: req[0] and req[3] held continuously -> grants alternate 0,3,0,3; macro off -> grants 0,0,0.
- Withdraw: req[1] pulsed low before arbitration while busy serving req[0] -> no ack[1]; req[1] dropped after grant -> ack[1] still issued.
- Address change after grant: addr slice changed during ACCESS -> rdata reflects address latched at grant.
